// File: rtl/fp32_pkg.sv
// fp32_pkg: shared binary32 constants, operand classes and classification helper
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;
  function automatic fp_class_t classify(input logic [31:0] x);
    return x[30:23] == 8'h00 ? ZERO : x[30:23] != 8'hFF ? NORM : x[22:0] == 23'd0 ? INF : NAN;
  endfunction
endpackage

// File: rtl/rca.sv
// rca: parameterised ripple-carry adder; callers subtract by passing ~b with cin=1
module rca #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[W];
endmodule

// File: rtl/add_sub.sv
// add_sub: binary32 adder/subtractor, RNE rounding, flush-to-zero, registered result
module add_sub
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        add_or_sub,
  output logic [31:0] S
);
  fp_class_t ca, cb;
  logic sa, sb, swap, s_l, s_s, op, cout, g, rb, st, up;
  logic [7:0] e_l, e_s, diff;
  logic [23:0] m_l, m_s;
  logic [49:0] wide;
  logic [26:0] aligned, b_op, sum, norm;
  logic [27:0] r;
  logic [4:0] lz;
  logic signed [9:0] e_n, e_f;
  logic [24:0] m_r;
  logic [22:0] frac;
  logic [31:0] norm_res, res;
  assign ca = classify(A);
  assign cb = classify(B);
  assign sa = A[31];
  assign sb = B[31] ^ add_or_sub;
  assign swap = B[30:0] > A[30:0];
  assign {s_l, e_l, m_l} = swap ? {sb, B[30:23], 1'b1, B[22:0]} : {sa, A[30:23], 1'b1, A[22:0]};
  assign {s_s, e_s, m_s} = swap ? {sa, A[30:23], 1'b1, A[22:0]} : {sb, B[30:23], 1'b1, B[22:0]};
  assign op = s_l ^ s_s;
  assign diff = e_l - e_s;
  // bits shifted past guard/round collapse into sticky; 26+ leaves only sticky
  assign wide = {m_s, 26'd0} >> diff;
  assign aligned = diff >= 8'd26 ? 27'd1 : {wide[49:24], |wide[23:0]};
  assign b_op = op ? ~aligned : aligned;
  rca #(.W(27)) u_sig (
    .a({m_l, 3'b000}),
    .b(b_op),
    .cin(op),
    .sum(sum),
    .cout(cout)
  );
  assign r = {cout & ~op, sum};
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) lz = r[i] ? 5'(26 - i) : lz;
  end
  assign norm = r[27] ? {r[27:2], r[1] | r[0]} : r[26:0] << lz;
  assign e_n = r[27] ? 10'({2'b00, e_l}) + 10'd1 : 10'({2'b00, e_l}) - 10'({5'd0, lz});
  assign g = norm[2];
  assign rb = norm[1];
  assign st = norm[0];
  assign up = g & (rb | st | norm[3]);
  assign m_r = {1'b0, norm[26:3]} + 25'(up);
  assign e_f = e_n + 10'(m_r[24]);
  assign frac = m_r[24] ? m_r[23:1] : m_r[22:0];
  assign norm_res = r == 28'd0 ? 32'd0 :
                    e_f > 10'sd254 ? {s_l, POS_INF[30:0]} :
                    e_f < 10'sd1 ? {s_l, 31'd0} : {s_l, e_f[7:0], frac};
  assign res = (ca == NAN || cb == NAN) ? QNAN :
               (ca == INF && cb == INF && sa != sb) ? QNAN :
               ca == INF ? (sa ? NEG_INF : POS_INF) :
               cb == INF ? (sb ? NEG_INF : POS_INF) :
               (ca == ZERO && cb == ZERO) ? {sa & sb, 31'd0} :
               ca == ZERO ? {sb, B[30:0]} :
               cb == ZERO ? {sa, A[30:0]} : norm_res;
  always_ff @(posedge clk) S <= rst ? 32'd0 : res;
endmodule

// File: tb/tb_add_sub.sv
// tb_add_sub: directed and random checks of add_sub against an exact-integer reference
module tb_add_sub;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] A, B, S;
  logic add_or_sub;
  int passed = 0;
  int total = 0;
  int fails = 0;
  add_sub dut (
    .clk(clk),
    .rst(rst),
    .S(S),
    .A(A),
    .B(B),
    .add_or_sub(add_or_sub)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic sa, sb, za, zb, ia, ib, na, nb, s;
    int ea, eb, em, p, sh, e;
    longint va, vb, t;
    longint unsigned m, mant, rem, half;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = ea == 0;
    zb = eb == 0;
    ia = ea == 255 && a[22:0] == 23'd0;
    ib = eb == 255 && b[22:0] == 23'd0;
    na = ea == 255 && a[22:0] != 23'd0;
    nb = eb == 255 && b[22:0] != 23'd0;
    if (na || nb) return 32'h7FC00000;
    if (ia && ib && sa != sb) return 32'h7FC00000;
    if (ia) return {sa, 8'hFF, 23'd0};
    if (ib) return {sb, 8'hFF, 23'd0};
    if (za && zb) return {sa & sb, 31'd0};
    if (za) return {sb, b[30:0]};
    if (zb) return {sa, a[30:0]};
    em = ea < eb ? ea : eb;
    va = longint'({1'b1, a[22:0]}) << (ea - em);
    vb = longint'({1'b1, b[22:0]}) << (eb - em);
    if (sa) va = -va;
    if (sb) vb = -vb;
    t = va + vb;
    if (t == 0) return 32'd0;
    s = t < 0;
    m = s ? longint'(-t) : longint'(t);
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    e = em + p - 23;
    if (p <= 23) mant = m << (23 - p);
    else begin
      sh = p - 23;
      mant = m >> sh;
      rem = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        e = e + 1;
      end
    end
    if (e > 254) return s ? 32'hFF800000 : 32'h7F800000;
    if (e < 1) return {s, 31'd0};
    return {s, 8'(e), mant[22:0]};
  endfunction
  function automatic logic [31:0] rnd_op(input int base);
    int k, e;
    logic sg;
    k = int'($urandom_range(0, 31));
    sg = 1'($urandom_range(0, 1));
    e = base + int'($urandom_range(0, 34)) - 17;
    e = e < 1 ? 1 : e > 254 ? 254 : e;
    if (k == 0) return {sg, 31'd0};
    if (k == 1) return {sg, 8'd0, 23'($urandom) | 23'd1};
    if (k == 2) return {sg, 8'hFF, 23'd0};
    if (k == 3) return {sg, 8'hFF, 23'($urandom) | 23'd1};
    if (k == 4) return {sg, 8'(e), 23'h7FFFFF};
    return {sg, 8'(e), 23'($urandom)};
  endfunction
  task automatic check(input string tag, input logic [31:0] exp_v);
    total++;
    assert (S === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s: S=%h expected %h", tag, S, exp_v);
    end
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                     input logic [31:0] exp_v);
    A = a;
    B = b;
    add_or_sub = sub;
    @(posedge clk);
    #1;
    check(tag, exp_v);
  endtask
  initial begin
    logic [31:0] ra, rb;
    logic rs;
    int base;
    rst = 1'b1;
    A = 32'h41100000;
    B = 32'h41600000;
    add_or_sub = 1'b0;
    @(posedge clk);
    #1;
    check("reset0", 32'd0);
    @(posedge clk);
    #1;
    check("reset1", 32'd0);
    rst = 1'b0;
    run("first_after_rst", 32'h41100000, 32'h41600000, 1'b0, 32'h41B80000);
    run("tie_even", 32'h41CB1893, 32'h419F8000, 1'b0, 32'h42354C4A);
    run("mixed_sign_add", 32'hC1F0E148, 32'h4278D2F2, 1'b0, 32'h4200624E);
    run("neg_sub", 32'hC1740000, 32'h40166666, 1'b1, 32'hC18CCCCD);
    run("carry_out", 32'h465AC000, 32'h46DAC000, 1'b0, 32'h47241000);
    run("align_add", 32'h41E40000, 32'h40F40000, 1'b0, 32'h42108000);
    run("inf_plus_zero", 32'h7F800000, 32'h00000000, 1'b0, 32'h7F800000);
    run("inf_plus_inf", 32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000);
    run("neg_inf_plus_x", 32'hFF800000, 32'h40166666, 1'b0, 32'hFF800000);
    run("zero_minus_zero", 32'h00000000, 32'h00000000, 1'b1, 32'h00000000);
    run("negz_plus_negz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
    run("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
    run("ninf_minus_ninf", 32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000);
    run("nan_in", 32'h7FFFFFFF, 32'h40166666, 1'b1, 32'h7FC00000);
    run("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
    run("cancel", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
    run("denorm_flush", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000);
    run("underflow", 32'h00C00000, 32'h00800000, 1'b1, 32'h00000000);
    rst = 1'b1;
    A = 32'h41CB1893;
    B = 32'h419F8000;
    @(posedge clk);
    #1;
    check("rst_mid", 32'd0);
    rst = 1'b0;
    run("after_mid_rst", 32'h41CB1893, 32'h419F8000, 1'b0, 32'h42354C4A);
    for (int n = 0; n < 2000; n++) begin
      base = int'($urandom_range(1, 254));
      ra = rnd_op(base);
      rb = rnd_op(base);
      if ($urandom_range(0, 7) == 0) rb = ra ^ 32'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      run("random", ra, rb, rs, ref_model(ra, rb, rs));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
